uart_rx_core: RTL and testbench

- Receive end of the team's UART link; counterpart to the UART transmitter (start bit, LSB-first data, optional parity, one stop bit, line idles high).
- Oversamples RX_IN at a runtime prescale and majority-votes the three mid-bit samples.
- Deserializes each frame and checks parity and stop bit.
- Presents each good byte as a one-cycle data_valid pulse to the system control logic.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_sampler.sv | 45 ++++
 rtl/uart_rx_core.sv | 162 ++++++++++++++++
 tb/tb_uart_rx_core.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam logic PAR_EVEN     = 1'b0;
    localparam logic PAR_ODD      = 1'b1;
    localparam int   MIN_PRESCALE = 8;

    // Parity bit the transmitter should have sent for a payload whose bits XOR to data_xor.
    function automatic logic expected_parity(input logic data_xor, input logic par_typ);
        return (par_typ == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and three-sample majority vote around the bit centre.
module uart_rx_sampler #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run_i,
    input  logic                  rx_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic                  sampled_bit_o,
    output logic                  sample_strobe_o,
    output logic                  bit_end_o
);

    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [PRESCALE_W-1:0] half;
    logic                  s0_q, s1_q;

    assign half            = prescale_i >> 1;
    assign bit_end_o       = (edge_cnt_q == prescale_i - PRESCALE_W'(1));
    assign sample_strobe_o = (edge_cnt_q == half);
    // Third vote is the live line value at the centre edge itself.
    assign sampled_bit_o   = (s0_q & s1_q) | (s0_q & rx_i) | (s1_q & rx_i);

    always_comb begin
        edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
        if (!run_i || bit_end_o) begin
            edge_cnt_d = '0;
        end
    end

    // NOTE: non-blocking assignments so every flop captures its pre-edge inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt_q <= '0;
            s0_q       <= 1'b1;
            s1_q       <= 1'b1;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            if (run_i && edge_cnt_q == half - PRESCALE_W'(2)) s0_q <= rx_i;
            if (run_i && edge_cnt_q == half - PRESCALE_W'(1)) s1_q <= rx_i;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: frame FSM, parity/stop checking and byte hand-off.
// Define UART_RX_SYNC_EN to pass RX_IN through a two-flop synchronizer first.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_CNT_W-1:0]  LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_W-1:0] MIN_P    = PRESCALE_W'(MIN_PRESCALE);

    logic rx;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) sync_q <= 2'b11;
        else      sync_q <= {sync_q[0], RX_IN};
    end
    assign rx = sync_q[1];
`else
    assign rx = RX_IN;
`endif

    rx_state_e             state_q, state_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  par_en_q, par_en_d, par_typ_q, par_typ_d;
    logic                  par_fail_q, par_fail_d, stop_ok_q, stop_ok_d;
    logic                  valid_q, valid_d, par_err_q, par_err_d, stp_err_q, stp_err_d;
    logic [PRESCALE_W-1:0] prescale_even, prescale_eff;
    logic                  sampled_bit, sample_strobe, bit_end;

    assign prescale_even = Prescale & ~PRESCALE_W'(1);
    assign prescale_eff  = (prescale_even < MIN_P) ? MIN_P : prescale_even;

    uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
        .clk             (CLK),
        .rst_n           (RST),
        .run_i           (state_q != IDLE),
        .rx_i            (rx),
        .prescale_i      (prescale_q),
        .sampled_bit_o   (sampled_bit),
        .sample_strobe_o (sample_strobe),
        .bit_end_o       (bit_end)
    );

    always_comb begin
        // NOTE: every next-state value is defaulted first so no latch is inferred.
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        p_data_d   = p_data_q;
        prescale_d = prescale_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        par_fail_d = par_fail_q;
        stop_ok_d  = stop_ok_q;
        valid_d    = 1'b0;
        par_err_d  = 1'b0;
        stp_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx) state_d = START;
            end
            START: begin
                if (sample_strobe && sampled_bit) begin
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (sample_strobe) shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                if (bit_end) begin
                    if (bit_cnt_q == LAST_BIT) state_d = par_en_q ? PARITY : STOP;
                    else                       bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                end
            end
            PARITY: begin
                if (sample_strobe && sampled_bit != expected_parity(^shift_q, par_typ_q)) begin
                    par_fail_d = 1'b1;
                end
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (sample_strobe) stop_ok_d = sampled_bit;
                if (bit_end) begin
                    par_err_d = par_fail_q;
                    stp_err_d = ~stop_ok_q;
                    if (!par_fail_q && stop_ok_q) begin
                        valid_d  = 1'b1;
                        p_data_d = shift_q;
                    end
                    state_d = rx ? IDLE : START;
                end
            end
            default: state_d = IDLE;
        endcase

        // Any entry into START is a fresh start detection: capture the frame's configuration.
        if (state_d == START && state_q != START) begin
            prescale_d = prescale_eff;
            par_en_d   = PAR_EN;
            par_typ_d  = PAR_TYP;
            par_fail_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            p_data_q   <= '0;
            prescale_q <= MIN_P;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_fail_q <= 1'b0;
            stop_ok_q  <= 1'b1;
            valid_q    <= 1'b0;
            par_err_q  <= 1'b0;
            stp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            p_data_q   <= p_data_d;
            prescale_q <= prescale_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            par_fail_q <= par_fail_d;
            stop_ok_q  <= stop_ok_d;
            valid_q    <= valid_d;
            par_err_q  <= par_err_d;
            stp_err_q  <= stp_err_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign data_valid = valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: directed frames push expected pulses, a monitor pops and compares.
module tb_uart_rx_core;
    import uart_pkg::*;

    localparam int PW = 6;
`ifdef UART_RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    typedef struct {
        logic [2:0] flags;   // {data_valid, par_err, stp_err}
        logic [7:0] pdata;
        int         cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx = 1'b1;
    logic [PW-1:0] prescale = PW'(8);
    logic          par_en = 1'b0;
    logic          par_typ = 1'b0;
    logic [7:0]    p_data;
    logic          data_valid, par_err, stp_err;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    logic [7:0] last_good = 8'h00;

    uart_rx_core #(.DATA_WIDTH(8), .PRESCALE_W(PW)) dut (
        .CLK        (clk),
        .RST        (rst_n),
        .RX_IN      (rx),
        .Prescale   (prescale),
        .PAR_EN     (par_en),
        .PAR_TYP    (par_typ),
        .P_DATA     (p_data),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_bit(input logic b, input int n);
        rx = b;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends one frame with bp clocks per bit; the pulse is due one clock after the last frame clock.
    task automatic send_frame(input logic [7:0] data, input logic [PW-1:0] pre, input int bp,
                              input logic pe, input logic pt, input logic pbit, input logic sbit,
                              input logic [2:0] exp_flags, input logic [PW-1:0] mid_pre);
        exp_t e;
        prescale = pre;
        par_en   = pe;
        par_typ  = pt;
        e.flags  = exp_flags;
        if (exp_flags[2]) last_good = data;
        e.pdata  = last_good;
        e.cyc    = cyc + 1 + (10 + int'(pe)) * bp + SYNC_LAT;
        sb_q.push_back(e);
        drive_bit(1'b0, bp);
        if (mid_pre != '0) begin
            prescale = mid_pre;
            par_typ  = ~pt;
            par_en   = ~pe;
        end
        for (int i = 0; i < 8; i++) drive_bit(data[i], bp);
        if (pe) drive_bit(pbit, bp);
        drive_bit(sbit, bp);
        par_en  = pe;
        par_typ = pt;
    endtask

    always @(negedge clk) begin
        if (rst_n && (data_valid || par_err || stp_err)) begin
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", {29'd0, data_valid, par_err, stp_err}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("out_flags", {29'd0, data_valid, par_err, stp_err}, {29'd0, e.flags});
                check("p_data", {24'd0, p_data}, {24'd0, e.pdata});
                check("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_p_data", {24'd0, p_data}, 32'd0);
        check("reset_data_valid", {31'd0, data_valid}, 32'd0);
        check("reset_par_err", {31'd0, par_err}, 32'd0);
        check("reset_stp_err", {31'd0, stp_err}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_bit(1'b1, 10);

        // Clean byte, no parity, minimum prescale.
        send_frame(8'hA5, PW'(8), 8, 1'b0, PAR_EVEN, 1'b0, 1'b1, 3'b100, '0);
        drive_bit(1'b1, 10);
        // Even parity expected 0 for 0x3C, sending 1.
        send_frame(8'h3C, PW'(16), 16, 1'b1, PAR_EVEN, 1'b1, 1'b1, 3'b010, '0);
        drive_bit(1'b1, 10);
        // Stop bit low, then a good frame after idle.
        send_frame(8'h81, PW'(32), 32, 1'b0, PAR_EVEN, 1'b0, 1'b0, 3'b001, '0);
        drive_bit(1'b1, 40);
        send_frame(8'h7E, PW'(32), 32, 1'b0, PAR_EVEN, 1'b0, 1'b1, 3'b100, '0);
        drive_bit(1'b1, 10);
        // Three-clock glitch is rejected, then a real frame.
        prescale = PW'(16);
        drive_bit(1'b0, 3);
        drive_bit(1'b1, 30);
        send_frame(8'h55, PW'(16), 16, 1'b0, PAR_EVEN, 1'b0, 1'b1, 3'b100, '0);
        drive_bit(1'b1, 10);
        // Back-to-back, odd parity: 0x01 and 0xFE both need parity bit 0.
        send_frame(8'h01, PW'(8), 8, 1'b1, PAR_ODD, 1'b0, 1'b1, 3'b100, '0);
        send_frame(8'hFE, PW'(8), 8, 1'b1, PAR_ODD, 1'b0, 1'b1, 3'b100, '0);
        drive_bit(1'b1, 10);
        // Parity and stop errors together on one frame.
        send_frame(8'h0F, PW'(8), 8, 1'b1, PAR_EVEN, 1'b1, 1'b0, 3'b011, '0);
        drive_bit(1'b1, 20);
        // Prescale 6 is clamped to 8.
        send_frame(8'h5A, PW'(6), 8, 1'b0, PAR_EVEN, 1'b0, 1'b1, 3'b100, '0);
        drive_bit(1'b1, 10);
        // Prescale 17 rounds to 16; config changes after start must be ignored.
        send_frame(8'hC3, PW'(17), 16, 1'b1, PAR_EVEN, 1'b0, 1'b1, 3'b100, PW'(8));
        drive_bit(1'b1, 10);

        // Back-to-back again, with reset asserted in the middle of the second frame.
        send_frame(8'h01, PW'(8), 8, 1'b1, PAR_ODD, 1'b0, 1'b1, 3'b100, '0);
        drive_bit(1'b0, 8);
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 12);
        rst_n = 1'b0;
        rx    = 1'b1;
        last_good = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midreset_p_data", {24'd0, p_data}, 32'd0);
        check("midreset_data_valid", {31'd0, data_valid}, 32'd0);
        check("midreset_par_err", {31'd0, par_err}, 32'd0);
        check("midreset_stp_err", {31'd0, stp_err}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_bit(1'b1, 120);

        for (int i = 0; i < 2000 && sb_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
